// File: rtl/or1200_dmmu_tlb_sa.sv
// Set-associative data TLB with DMMU control: parallel way lookup, per-set
// round-robin victim pointers, miss capture register and flush-all sequencer.
module or1200_dmmu_tlb_sa #(
  parameter int AW         = 32,
  parameter int PAGE_SHIFT = 13,
  parameter int SETS_LOG2  = 6,
  parameter int WAYS       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dc_en,
  input  logic          dmmu_en,
  input  logic          supv,
  input  logic [AW-1:0] dcpu_adr_i,
  input  logic          dcpu_cycstb_i,
  input  logic          dcpu_we_i,
  output logic [3:0]    dcpu_tag_o,
  output logic          dcpu_err_o,
  output logic          dcpu_rty_o,
  input  logic          spr_cs,
  input  logic          spr_write,
  input  logic [31:0]   spr_addr,
  input  logic [31:0]   spr_dat_i,
  output logic [31:0]   spr_dat_o,
  input  logic          qmemdmmu_err_i,
  input  logic [3:0]    qmemdmmu_tag_i,
  output logic [AW-1:0] qmemdmmu_adr_o,
  output logic          qmemdmmu_cycstb_o,
  output logic          qmemdmmu_ci_o
);

  localparam int SETS = 1 << SETS_LOG2;
  localparam int VW   = AW - PAGE_SHIFT;
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  // Entry storage; attr packs {swe, sre, uwe, ure, ci}
  logic          v_mem    [WAYS][SETS];
  logic [VW-1:0] vpn_mem  [WAYS][SETS];
  logic [VW-1:0] ppn_mem  [WAYS][SETS];
  logic [4:0]    attr_mem [WAYS][SETS];

  state_t                state_q, state_d;
  logic [SETS_LOG2-1:0]  cnt_q, cnt_d;
  logic [WB-1:0]         victim_q [SETS];
  logic [WB-1:0]         victim_d [SETS];
  logic                  rty_q, rty_d, lerr_q, lerr_d, fwd_q, fwd_d, ci_q, ci_d;
  logic [3:0]            ltag_q, ltag_d;
  logic [AW-1:0]         adr_q, adr_d;
  logic [VW-1:0]         mr_vpn_q, mr_vpn_d;
  logic [1:0]            mr_way_q, mr_way_d;

  logic [SETS_LOG2-1:0]  set_idx;
  logic [VW-1:0]         adr_vpn;
  logic [WAYS-1:0]       way_hit;
  logic                  hit, perm_ok;
  logic [VW-1:0]         hit_ppn;
  logic [4:0]            hit_attr;

  logic [10:0]           sa;
  logic [SETS_LOG2-1:0]  spr_set;
  logic [WB-1:0]         spr_way;
  logic                  spr_wr, entry_wr, flush_req;
  logic                  unused_bits;

  assign set_idx = dcpu_adr_i[PAGE_SHIFT +: SETS_LOG2];
  assign adr_vpn = dcpu_adr_i[AW-1:PAGE_SHIFT];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_hit[gi] = v_mem[gi][set_idx] && (vpn_mem[gi][set_idx] == adr_vpn);
    end
  endgenerate

  // Scan downwards so the lowest-numbered hitting way is the one kept
  always_comb begin
    hit      = 1'b0;
    hit_ppn  = '0;
    hit_attr = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit      = 1'b1;
        hit_ppn  = ppn_mem[w][set_idx];
        hit_attr = attr_mem[w][set_idx];
      end
    end
  end

  assign perm_ok = supv ? (dcpu_we_i ? hit_attr[4] : hit_attr[3])
                        : (dcpu_we_i ? hit_attr[2] : hit_attr[1]);

  assign sa        = spr_addr[10:0];
  assign spr_set   = sa[SETS_LOG2-1:0];
  assign spr_way   = (WAYS > 1) ? sa[7 +: WB] : '0;
  assign spr_wr    = spr_cs & spr_write;
  assign entry_wr  = spr_wr & sa[10] & (state_q == IDLE);
  assign flush_req = spr_wr & (sa == 11'h002) & spr_dat_i[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (flush_req) begin
          cnt_d = '0;
        end else if (cnt_q == SETS_LOG2'(SETS - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_comb begin
    victim_d = victim_q;
    rty_d    = 1'b0;
    lerr_d   = 1'b0;
    ltag_d   = 4'h0;
    fwd_d    = 1'b0;
    adr_d    = adr_q;
    ci_d     = ci_q;
    mr_vpn_d = mr_vpn_q;
    mr_way_d = mr_way_q;
    if (dcpu_cycstb_i) begin
      if (!dmmu_en) begin
        fwd_d = 1'b1;
        adr_d = dcpu_adr_i;
        ci_d  = ~dc_en;
      end else if (state_q == FLUSH) begin
        rty_d = 1'b1;
      end else if (hit && perm_ok) begin
        fwd_d = 1'b1;
        adr_d = {hit_ppn, dcpu_adr_i[PAGE_SHIFT-1:0]};
        ci_d  = hit_attr[0] | ~dc_en;
      end else if (hit) begin
        lerr_d = 1'b1;
        ltag_d = 4'hB;
      end else begin
        lerr_d   = 1'b1;
        ltag_d   = 4'hA;
        mr_vpn_d = adr_vpn;
        mr_way_d = 2'(victim_q[set_idx]);
        victim_d[set_idx] = (WAYS > 1) ? victim_q[set_idx] + WB'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FLUSH;
      cnt_q    <= '0;
      rty_q    <= 1'b0;
      lerr_q   <= 1'b0;
      ltag_q   <= 4'h0;
      fwd_q    <= 1'b0;
      adr_q    <= '0;
      ci_q     <= 1'b0;
      mr_vpn_q <= '0;
      mr_way_q <= 2'b00;
      for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rty_q    <= rty_d;
      lerr_q   <= lerr_d;
      ltag_q   <= ltag_d;
      fwd_q    <= fwd_d;
      adr_q    <= adr_d;
      ci_q     <= ci_d;
      mr_vpn_q <= mr_vpn_d;
      mr_way_q <= mr_way_d;
      victim_q <= victim_d;
    end
  end

  // Entry arrays carry no reset: the post-reset flush invalidates every set
  always_ff @(posedge clk) begin
    if (state_q == FLUSH) begin
      for (int w = 0; w < WAYS; w++) v_mem[w][cnt_q] <= 1'b0;
    end else if (entry_wr) begin
      if (!sa[9]) begin
        v_mem[spr_way][spr_set]   <= spr_dat_i[0];
        vpn_mem[spr_way][spr_set] <= spr_dat_i[AW-1:PAGE_SHIFT];
      end else begin
        ppn_mem[spr_way][spr_set]  <= spr_dat_i[AW-1:PAGE_SHIFT];
        attr_mem[spr_way][spr_set] <= {spr_dat_i[9], spr_dat_i[8], spr_dat_i[7],
                                       spr_dat_i[6], spr_dat_i[1]};
      end
    end
  end

  always_comb begin
    spr_dat_o = 32'h0;
    if (sa[10]) begin
      if (!sa[9]) begin
        spr_dat_o[0]               = v_mem[spr_way][spr_set];
        spr_dat_o[AW-1:PAGE_SHIFT] = vpn_mem[spr_way][spr_set];
      end else begin
        spr_dat_o[AW-1:PAGE_SHIFT] = ppn_mem[spr_way][spr_set];
        spr_dat_o[9]               = attr_mem[spr_way][spr_set][4];
        spr_dat_o[8]               = attr_mem[spr_way][spr_set][3];
        spr_dat_o[7]               = attr_mem[spr_way][spr_set][2];
        spr_dat_o[6]               = attr_mem[spr_way][spr_set][1];
        spr_dat_o[1]               = attr_mem[spr_way][spr_set][0];
      end
    end else if (sa == 11'h002) begin
      spr_dat_o[1] = (state_q == FLUSH);
    end else if (sa == 11'h003) begin
      spr_dat_o[AW-1:PAGE_SHIFT] = mr_vpn_q;
      spr_dat_o[1:0]             = mr_way_q;
    end
  end

  assign dcpu_rty_o        = rty_q;
  assign dcpu_err_o        = lerr_q | (fwd_q & qmemdmmu_err_i);
  assign dcpu_tag_o        = lerr_q ? ltag_q : (fwd_q ? qmemdmmu_tag_i : 4'h0);
  assign qmemdmmu_cycstb_o = fwd_q;
  assign qmemdmmu_adr_o    = adr_q;
  assign qmemdmmu_ci_o     = ci_q;

  assign unused_bits = ^{spr_addr, spr_dat_i};

endmodule

// File: doc/or1200_dmmu_tlb_sa.md
# or1200_dmmu_tlb_sa

Parametrised set-associative data TLB with integrated DMMU control, the next-generation replacement for the direct-mapped DTLB inside the OR1200 DMMU. It translates load/store virtual addresses from the CPU into physical addresses for the QMEM/DC side and flags TLB misses and page-protection faults. It provides per-set round-robin victim selection, a miss-capture register to help software refill, and a hardware flush-all sequencer. It sits between the CPU LSU and `or1200_qmem_top`, and is programmed through SPR group 1.

## Interface
Parameters:
- `AW`, 32, virtual/physical address width.
- `PAGE_SHIFT`, 13, log2 of page size (8 KB).
- `SETS_LOG2`, 6, log2 of set count (legal range 1..7).
- `WAYS`, 2, associativity (legal values 1, 2, 4).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `dc_en`  in  1  data cache enable.
- `dmmu_en`  in  1  translation enable.
- `supv`  in  1  supervisor mode.
- `dcpu_adr_i`  in  AW  virtual address.
- `dcpu_cycstb_i`  in  1  access request.
- `dcpu_we_i`  in  1  1 = store.
- `dcpu_tag_o`  out  4  0 = ok, 4'hA = TLB miss, 4'hB = page fault.
- `dcpu_err_o`  out  1  miss or fault.
- `dcpu_rty_o`  out  1  retry; the TLB is flushing.
- `spr_cs`  in  1  SPR group-1 select.
- `spr_write`  in  1  SPR write strobe.
- `spr_addr`  in  32  SPR address (bits 10:0 decoded).
- `spr_dat_i`  in  32  SPR write data.
- `spr_dat_o`  out  32  SPR read data, combinational.
- `qmemdmmu_err_i`  in  1  downstream bus error.
- `qmemdmmu_tag_i`  in  4  downstream tag.
- `qmemdmmu_adr_o`  out  AW  physical address.
- `qmemdmmu_cycstb_o`  out  1  physical request.
- `qmemdmmu_ci_o`  out  1  cache inhibit.

## Operation
SPR map (`spr_addr[10:0]`):
- Bit 10 = 1 selects a TLB entry.
  - Bit 9 selects the register: 0 = match, 1 = translate.
  - Bits 8:7 give the way.
  - Bits 6:0 give the set.
  - Way or set bits beyond `WAYS` or `SETS` are ignored.
- 11'h002 is DMMUCR.
  - Writing bit0 = 1 starts a flush.
  - Reading returns bit1 = busy; all other bits read 0.
- 11'h003 is DMMUMR, read-only.
  - Bits `[AW-1:PAGE_SHIFT]` hold the VPN of the last miss.
  - Bits 1:0 hold the victim way for that miss.
- Unmapped addresses read 0; writes to them are ignored.

Register formats:
- Match register: bit0 = V, bits `[AW-1:PAGE_SHIFT]` = VPN.
- Translate register: bit1 = CI, bit6 = URE, bit7 = UWE, bit8 = SRE, bit9 = SWE, bits `[AW-1:PAGE_SHIFT]` = PPN.
- Fields not listed are stored and read back as 0.

Lookup:
- The set index is `adr[PAGE_SHIFT+SETS_LOG2-1:PAGE_SHIFT]`.
- All ways are compared in parallel: a way hits when V = 1 and its VPN equals the address VPN.
- When several ways hit, the lowest-numbered way wins.
- A hit passes the permission check when `supv ? (we ? SWE : SRE) : (we ? UWE : URE)` is 1; otherwise it is a page fault.

Miss handling:
- On a miss, the per-set victim pointer advances by 1 modulo `WAYS`.
- DMMUMR captures the address VPN and the pointer value before the increment.

Pass-through:
- With `dmmu_en` = 0, physical address = virtual address.
- No miss or fault is raised and `qmemdmmu_ci_o` = `~dc_en`.
- With translation active, `qmemdmmu_ci_o` = `CI | ~dc_en`.

Flush FSM:
- States are IDLE and FLUSH.
- In FLUSH, a set counter clears V in all ways of one set per cycle, starting from set 0.
- FLUSH returns to IDLE after set `SETS-1` is cleared, so a flush takes `SETS` cycles.
- Reset forces FLUSH with counter = 0, so the entry arrays need no reset.
- A flush request received while flushing restarts the counter at 0.
- SPR TLB-entry writes during FLUSH are dropped.

## Timing
- Lookup latency is 1 cycle.
  - Request in cycle N.
  - In cycle N+1, registered outputs apply: `qmemdmmu_cycstb_o`/`adr_o`/`ci_o` on a hit or in pass-through, or `dcpu_err_o` with the tag on a miss or fault.
  - A miss or fault never asserts `qmemdmmu_cycstb_o`.
- `dcpu_tag_o`:
  - Forwards `qmemdmmu_tag_i` for a passed access.
  - Returns the local miss/fault tag for a miss or fault.
- `dcpu_err_o` also asserts in cycle N+1 when `qmemdmmu_err_i` is 1 during a forwarded access.
- During FLUSH, with `dmmu_en` = 1, a request returns `dcpu_rty_o` = 1 in cycle N+1 and has no other effect.
- An SPR entry write takes effect at the edge.
  - A lookup in the same cycle uses the old contents.
  - The victim pointer is unchanged by SPR writes.
- Reset values of all outputs: `dcpu_tag_o` = 0, `dcpu_err_o` = 0, `dcpu_rty_o` = 0, `qmemdmmu_adr_o` = 0, `qmemdmmu_cycstb_o` = 0, `qmemdmmu_ci_o` = 0, DMMUMR = 0, victim pointers = 0.
- `spr_dat_o` follows `spr_addr`.
- Reset asserted mid-flush or mid-lookup cancels the operation; after reset the flush starts again from set 0.

## Test plan
- Release reset and hold `dmmu_en` = 1 with requests active → `dcpu_rty_o` = 1 for 64 cycles (default `SETS`), then DMMUCR bit1 = 0.
- Write the way-1, set-0 match register = 32'h0000_0001 (VPN 0) and translate register = 32'h0004_0302 (PPN 0x20, CI, SRE, SWE), then issue a supervisor store to 32'h0000_000D → next cycle `qmemdmmu_adr_o` = 32'h0004_000D, `cycstb_o` = 1, `ci_o` = 1.
- Issue a user load to the same page as the previous scenario (URE = 0) → `dcpu_err_o` = 1, `dcpu_tag_o` = 4'hB, `qmemdmmu_cycstb_o` = 0.
- Issue two misses to address 32'h0000_2000 (set 1) → DMMUMR = 32'h0000_2000 then 32'h0000_2001, tag 4'hA both times.
- Write DMMUCR = 1 after the fills, then repeat the previous hit access → miss, tag 4'hA.
- Set `dmmu_en` = 0 and `dc_en` = 0, then request address 3 → `qmemdmmu_adr_o` = 3 and `ci_o` = 1 one cycle later.
